// File: rtl/instr_receiver_pkg.sv
// instr_receiver_pkg: shared softMC constants, opcodes and receiver state encodings.
package instr_receiver_pkg;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 11;
    localparam int CNT_MAX = 2047;
    localparam logic [3:0] END_ISEQ = 4'hF;
    localparam logic [3:0] STOP     = 4'hE;
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RECV     = 2'b01,
        DISPATCH = 2'b10,
        DRAIN    = 2'b11
    } rx_state_t;
endpackage

// File: rtl/instr_receiver.sv
// instr_receiver: accepts upstream instructions into the FIFO and hands complete
// transactions (terminated by END_ISEQ) to the dispatcher.
module instr_receiver
    import instr_receiver_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               app_en,
    input  logic [INSTR_W-1:0] app_instr,
    output logic               app_ack,
    input  logic               looping,
    input  logic               dispatcher_busy,
    input  logic               fifo_full,
    output logic               fifo_wr_en,
    output logic [INSTR_W-1:0] fifo_data,
    output logic               process_tr,
    output logic [CNT_W-1:0]   instr_count,
    output logic               overflow,
    output logic [1:0]         state_out
);
    rx_state_t          r_state, w_next;
    logic               r_wr_en, r_pulse, r_overflow;
    logic [INSTR_W-1:0] r_data;
    logic [CNT_W-1:0]   r_count;
    logic               w_accept_ok, w_is_end, w_wr, w_start;

    assign w_accept_ok = !fifo_full && ((r_state == IDLE && !dispatcher_busy) || r_state == RECV);
    assign app_ack     = app_en && w_accept_ok && rst;
    assign w_is_end    = app_instr[31:28] == END_ISEQ;
    assign w_wr        = app_ack && !w_is_end;
    assign w_start     = app_ack && r_state == IDLE;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, RECV: w_next = !app_ack ? r_state : (w_is_end && !looping) ? DISPATCH : RECV;
            DISPATCH:   w_next = dispatcher_busy ? DRAIN : DISPATCH;
            DRAIN:      w_next = dispatcher_busy ? DRAIN : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_wr_en    <= 1'b0;
            r_data     <= '0;
            r_pulse    <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_wr;
            r_pulse <= app_ack && w_is_end && looping;
            if (w_wr)
                r_data <= app_instr;
            // A new transaction or a loop boundary restarts the count; the first word counts too
            if (w_start || (app_ack && w_is_end && looping))
                r_count <= w_wr ? CNT_W'(1) : '0;
            else if (w_wr && r_count != CNT_W'(CNT_MAX))
                r_count <= r_count + CNT_W'(1);
            if (w_start)
                r_overflow <= 1'b0;
            else if (w_wr && r_count == CNT_W'(CNT_MAX))
                r_overflow <= 1'b1;
        end
    end

    assign fifo_wr_en  = r_wr_en;
    assign fifo_data   = r_data;
    assign process_tr  = r_pulse || r_state == DISPATCH;
    assign instr_count = r_count;
    assign overflow    = r_overflow;
    assign state_out   = r_state;
endmodule

// File: tb/tb_instr_receiver.sv
// tb_instr_receiver: randomized stimulus checked cycle by cycle against a
// transaction-level reference model of the receiver.
module tb_instr_receiver;
    import instr_receiver_pkg::*;

    logic        clk = 1'b0;
    logic        rst, app_en, looping, dispatcher_busy, fifo_full;
    logic [31:0] app_instr;
    logic        app_ack, fifo_wr_en, process_tr, overflow;
    logic [31:0] fifo_data;
    logic [10:0] instr_count;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_errors = 0;

    int          m_st;
    bit          m_wr, m_pulse, m_ovf, m_ack;
    logic [31:0] m_data;
    int          m_total;
    int          n_writes, n_pulses, n_ovf_seen;

    always #5 clk = ~clk;

    instr_receiver dut (
        .clk(clk), .rst(rst), .app_en(app_en), .app_instr(app_instr), .app_ack(app_ack),
        .looping(looping), .dispatcher_busy(dispatcher_busy), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_data(fifo_data), .process_tr(process_tr),
        .instr_count(instr_count), .overflow(overflow), .state_out(state_out)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: one step per clock edge using the inputs held before that edge
    task automatic model_step();
        bit is_end;
        if (!rst) begin
            m_st = 0; m_wr = 0; m_data = '0; m_pulse = 0; m_total = 0; m_ovf = 0;
            return;
        end
        is_end  = app_instr[31:28] == END_ISEQ;
        m_wr    = m_ack && !is_end;
        m_pulse = m_ack && is_end && looping;
        if (m_wr) m_data = app_instr;
        if (m_st == 0 && m_ack) begin
            m_st = 1; m_total = 0; m_ovf = 0;
        end else if (m_st == 2 && dispatcher_busy) m_st = 3;
        else if (m_st == 3 && !dispatcher_busy) m_st = 0;
        if (m_ack) begin
            if (!is_end) begin
                m_total++;
                if (m_total > CNT_MAX) m_ovf = 1;
            end else if (looping) m_total = 0;
            else m_st = 2;
        end
    endtask

    task automatic check_regs();
        check("state", 32'(state_out), 32'(m_st));
        check("wr_en", 32'(fifo_wr_en), 32'(m_wr));
        check("data", fifo_data, m_data);
        check("process_tr", 32'(process_tr), 32'(m_st == 2 || m_pulse));
        check("instr_count", 32'(instr_count), 32'(m_total > CNT_MAX ? CNT_MAX : m_total));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (fifo_wr_en) n_writes++;
        if (process_tr && m_st != 2) n_pulses++;
        if (overflow) n_ovf_seen++;
    endtask

    task automatic drive(input int phase);
        logic [3:0] op;
        op = ($urandom_range(5) == 0) ? END_ISEQ : 4'($urandom_range(14));
        if (phase == 1) op = 4'($urandom_range(14));
        app_instr = {op, 28'($urandom)};
        app_en    = phase == 1 ? 1'b1 : 1'($urandom_range(3) != 0);
        looping   = 1'($urandom_range(1));
        fifo_full = phase == 1 ? 1'b0 : 1'($urandom_range(3) == 0);
        dispatcher_busy = phase == 1 ? 1'(m_st == 2) : 1'($urandom_range(2) == 0);
        rst       = phase == 1 ? 1'b1 : 1'($urandom_range(79) != 0);
        if (phase == 2) begin
            fifo_full = 1'b1;
            app_en    = 1'b1;
        end
    endtask

    initial begin
        rst = 1'b0; app_en = 1'b1; app_instr = 32'h1234_5678; looping = 1'b0;
        dispatcher_busy = 1'b0; fifo_full = 1'b0;
        n_writes = 0; n_pulses = 0; n_ovf_seen = 0;
        m_ack = 0;
        model_step();
        #1 check("ack_in_reset", 32'(app_ack), 32'd0);
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(posedge clk);
            model_step();
            #1 check_regs();
            // phase 1: long write burst to reach saturation; phase 2: held backpressure
            drive((cyc >= 3000 && cyc < 5400) ? 1 : (cyc >= 6000 && cyc < 6005) ? 2 : 0);
            if (cyc < 2) rst = 1'b0;
            m_ack = rst && app_en && !fifo_full && ((m_st == 0 && !dispatcher_busy) || m_st == 1);
            #1 check("app_ack", 32'(app_ack), 32'(m_ack));
        end
        check("writes_seen", 32'(n_writes > 100), 32'd1);
        check("pulses_seen", 32'(n_pulses > 5), 32'd1);
        check("overflow_seen", 32'(n_ovf_seen > 0), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/instr_receiver.md
INSTR_RECEIVER -- requirements
Module: instr_receiver

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-003 SHALL have port app_en  input  1  upstream instruction valid.
REQ-004 SHALL have port app_instr  input  32  instruction word; opcode in bits [31:28].
REQ-005 SHALL have port app_ack  output  1  instruction accepted this cycle (combinational).
REQ-006 SHALL have port looping  input  1  upstream buffer is replaying the program in a loop.
REQ-007 SHALL have port dispatcher_busy  input  1  transaction dispatcher is executing.
REQ-008 SHALL have port fifo_full  input  1  instruction FIFO almost-full; asserted with at least 1 free entry remaining.
REQ-009 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-010 SHALL have port fifo_data  output  32  FIFO write data.
REQ-011 SHALL have port process_tr  output  1  transaction-ready indication to the dispatcher.
REQ-012 SHALL have port instr_count  output  11  instructions written in the current transaction.
REQ-013 SHALL have port overflow  output  1  sticky: the transaction exceeded 2047 instructions.
REQ-014 SHALL have port state_out  output  2  current FSM state.

Function
REQ-015 SHALL implement states IDLE=00, RECV=01, DISPATCH=10 and DRAIN=11.
REQ-016 SHALL define accept_ok = ~fifo_full & ((IDLE & ~dispatcher_busy) | RECV), and app_ack = app_en & accept_ok; no acceptance in DISPATCH or DRAIN.
REQ-017 SHALL treat an instruction as transferred only in a cycle with app_en=1 and app_ack=1; otherwise app_instr is ignored and the upstream holds it.
REQ-018 SHALL transition IDLE->RECV on an accepted instruction, clear instr_count and overflow on that transition, and process that same instruction normally.
REQ-019 SHALL register each accepted non-END_ISEQ instruction: fifo_data=app_instr and fifo_wr_en=1 exactly 1 cycle later (latency 1), with at most one write per cycle.
REQ-020 SHALL hold fifo_wr_en=0 and fifo_data at its last value in every cycle following a cycle without an accepted non-END_ISEQ instruction.
REQ-021 SHALL never write END_ISEQ to the FIFO; STOP and all other opcodes are forwarded unchanged.
REQ-022 SHALL, when END_ISEQ is accepted with looping=0, go RECV->DISPATCH next cycle.
REQ-023 SHALL, when END_ISEQ is accepted with looping=1, stay in RECV, pulse process_tr for exactly 1 cycle (the cycle after acceptance) and clear instr_count.
REQ-024 SHALL drive process_tr=1 throughout DISPATCH, and go DISPATCH->DRAIN on the first cycle with dispatcher_busy=1.
REQ-025 SHALL drive process_tr=0 in DRAIN, and go DRAIN->IDLE on the first cycle with dispatcher_busy=0.
REQ-026 SHALL increment instr_count (registered) on each FIFO write, saturating at 2047; a write while at 2047 sets overflow=1, which holds until the next IDLE->RECV transition or reset.
REQ-027 SHALL give fifo_full priority: when fifo_full=1, app_ack=0 regardless of app_en, and the already-registered write still completes (this relies on the spare entry from REQ-008).
REQ-028 SHALL, when END_ISEQ arrives in the same cycle that fifo_full=1, not accept it; it is accepted in the first cycle with fifo_full=0.
REQ-029 SHALL ignore changes of looping except in the cycle END_ISEQ is accepted.
REQ-030 SHALL drive state_out directly from the state register.

Reset
REQ-031 SHALL, with rst=0 at a clock edge, set state=IDLE, fifo_wr_en=0, fifo_data=0, process_tr=0, instr_count=0 and overflow=0; app_ack=0 while rst=0.
REQ-032 SHALL, on reset mid-transaction, discard any pending registered write: no fifo_wr_en in the cycle after reset is applied.
REQ-033 SHALL, on the first cycle after rst returns to 1, accept instructions if IDLE acceptance conditions hold.

Structure
REQ-034 SHALL take opcode constants END_ISEQ and STOP, INSTR_W=32, CNT_W=11, CNT_MAX=2047 and the state encodings from the shared softMC package/include.
REQ-035 SHALL be a single module with the FSM, write register and counter; no sub-module.

Verification
REQ-036 Basic: 3 instructions then END_ISEQ, looping=0, FIFO empty -> 3 fifo_wr_en pulses, each 1 cycle after its ack; instr_count=3; process_tr=1 until dispatcher_busy=1.
REQ-037 Loop: looping=1, 2 instructions plus END_ISEQ, repeated twice -> 4 writes; process_tr pulses exactly twice, 1 cycle each; state stays RECV.
REQ-038 Backpressure: fifo_full=1 for 5 cycles with app_en=1 -> app_ack=0 throughout; no instruction lost or duplicated after release.
REQ-039 Overflow: 2049 instructions without END_ISEQ -> instr_count=2047 and overflow=1; both cleared on the next IDLE->RECV transition.
REQ-040 Reset: rst=0 in the cycle after an ack -> no write strobe follows; all outputs at reset values; IDLE.
REQ-041 Drain: dispatcher_busy=1 during IDLE with app_en=1 -> app_ack=0 until dispatcher_busy=0.
